// File: rtl/memory_router.sv
// Single-master, N-slave memory request router: decodes [base, top) windows,
// forwards a one-cycle request pulse and returns registered data, error or timeout.
module memory_router #(
    parameter int                   slaves    = 4,
    parameter logic [slaves*32-1:0] base_addr = {32'h200000, 32'h100000, 32'h20000, 32'h0},
    parameter logic [slaves*32-1:0] top_addr  = {32'h200010, 32'h100004, 32'h40000, 32'h20000},
    parameter int unsigned          timeout   = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   m_valid,
    input  logic                   m_instr,
    input  logic [31:0]            m_addr,
    input  logic [31:0]            m_wdata,
    input  logic [3:0]             m_wstrb,
    output logic                   m_ready,
    output logic [31:0]            m_rdata,
    output logic                   m_error,
    output logic [slaves-1:0]      s_valid,
    output logic                   s_instr,
    output logic [31:0]            s_addr,
    output logic [31:0]            s_wdata,
    output logic [3:0]             s_wstrb,
    input  logic [slaves-1:0]      s_ready,
    input  logic [slaves*32-1:0]   s_rdata
);

    localparam int SelW = (slaves > 1) ? $clog2(slaves) : 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR} state_t;

    state_t            state_q, state_d;
    logic [SelW-1:0]   sel_q, sel_d;
    logic              sInstr_q, sInstr_d;
    logic [31:0]       sAddr_q, sAddr_d;
    logic [31:0]       sWdata_q, sWdata_d;
    logic [3:0]        sWstrb_q, sWstrb_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       waitCnt_q, waitCnt_d;

    logic              hit;
    logic [SelW-1:0]   hitIdx;
    logic [31:0]       hitOffset;
    logic              selReady;
    logic [31:0]       selRdata;

    // Scan from the highest index down so the lowest matching window wins;
    // an empty window (base >= top) can never satisfy both compares.
    always_comb begin
        hit       = 1'b0;
        hitIdx    = '0;
        hitOffset = '0;
        for (int i = slaves - 1; i >= 0; i--) begin
            if (m_addr >= base_addr[i*32 +: 32] && m_addr < top_addr[i*32 +: 32]) begin
                hit       = 1'b1;
                hitIdx    = SelW'(i);
                hitOffset = m_addr - base_addr[i*32 +: 32];
            end
        end
    end

    always_comb begin
        selReady = 1'b0;
        selRdata = '0;
        s_valid  = '0;
        for (int i = 0; i < slaves; i++) begin
            if (sel_q == SelW'(i)) begin
                selReady   = s_ready[i];
                selRdata   = s_rdata[i*32 +: 32];
                s_valid[i] = (state_q == REQ);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        sInstr_d  = sInstr_q;
        sAddr_d   = sAddr_q;
        sWdata_d  = sWdata_q;
        sWstrb_d  = sWstrb_q;
        rdata_d   = rdata_q;
        waitCnt_d = waitCnt_q;
        case (state_q)
            IDLE: begin
                waitCnt_d = '0;
                if (m_valid) begin
                    if (hit) begin
                        sel_d    = hitIdx;
                        sInstr_d = m_instr;
                        sAddr_d  = hitOffset;
                        sWdata_d = m_wdata;
                        sWstrb_d = m_wstrb;
                        state_d  = REQ;
                    end else begin
                        rdata_d = '0;
                        state_d = ERR;
                    end
                end
            end
            REQ: begin
                waitCnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (selReady) begin
                    rdata_d = selRdata;
                    state_d = RESP;
                end else if (timeout != 0 && waitCnt_q == timeout - 1) begin
                    rdata_d = '0;
                    state_d = ERR;
                end else if (waitCnt_q != '1) begin
                    waitCnt_d = waitCnt_q + 32'd1;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            sInstr_q  <= 1'b0;
            sAddr_q   <= '0;
            sWdata_q  <= '0;
            sWstrb_q  <= '0;
            rdata_q   <= '0;
            waitCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            sInstr_q  <= sInstr_d;
            sAddr_q   <= sAddr_d;
            sWdata_q  <= sWdata_d;
            sWstrb_q  <= sWstrb_d;
            rdata_q   <= rdata_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    assign m_ready = (state_q == RESP) || (state_q == ERR);
    assign m_error = (state_q == ERR);
    assign m_rdata = rdata_q;
    assign s_instr = sInstr_q;
    assign s_addr  = sAddr_q;
    assign s_wdata = sWdata_q;
    assign s_wstrb = sWstrb_q;

endmodule

// File: tb/tb_memory_router.sv
// Directed bench for memory_router: table of mapped transactions plus hand-written
// sequences for unmapped access, timeout, reset mid-transaction and stray inputs.
module tb_memory_router;

    logic          clock = 1'b0;
    logic          reset;
    logic          m_valid, m_instr;
    logic [31:0]   m_addr, m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_ready, m_error;
    logic [31:0]   m_rdata;
    logic [3:0]    s_valid;
    logic          s_instr;
    logic [31:0]   s_addr, s_wdata;
    logic [3:0]    s_wstrb;
    logic [3:0]    s_ready;
    logic [127:0]  s_rdata;

    int passCount = 0;
    int checkCount = 0;

    localparam logic [127:0] IdleRdata = {32'h33333333, 32'h22222222, 32'h11111111, 32'h0F0F0F0F};

    always #5 clock = ~clock;

    memory_router #(.timeout(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .m_valid (m_valid),
        .m_instr (m_instr),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_ready (m_ready),
        .m_rdata (m_rdata),
        .m_error (m_error),
        .s_valid (s_valid),
        .s_instr (s_instr),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_ready (s_ready),
        .s_rdata (s_rdata)
    );

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        instr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          slave;
        logic [31:0] rdata;
        int          readyDelay;
        logic [3:0]  strayReady;
        logic [3:0]  expSvalid;
        logic [31:0] expSaddr;
        int          expCycle;
    } vec_t;

    vec_t vectors [7];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Cycle 0 is the negedge where m_valid is driven; everything is driven and
    // sampled on negedges so cycle c's outputs are read in the middle of cycle c.
    task automatic applyStimulus(input vec_t v);
        int          respCycle;
        logic [31:0] gotRdata, gotSaddr;
        logic        gotErr;
        respCycle = -1;
        gotRdata  = 'x;
        gotSaddr  = 'x;
        gotErr    = 1'bx;
        @(negedge clock);
        m_valid = 1'b1;
        m_addr  = v.addr;
        m_instr = v.instr;
        m_wdata = v.wdata;
        m_wstrb = v.wstrb;
        @(negedge clock);
        m_valid = 1'b0;
        checkOutput({v.name, " s_valid"}, 32'(s_valid), 32'(v.expSvalid));
        checkOutput({v.name, " s_addr"},  s_addr, v.expSaddr);
        checkOutput({v.name, " s_wdata"}, s_wdata, v.wdata);
        checkOutput({v.name, " s_wstrb/instr"}, {s_wstrb, s_instr}, {v.wstrb, v.instr});
        for (int c = 2; c <= 12; c++) begin
            @(negedge clock);
            m_valid = 1'b0;
            s_rdata = IdleRdata;
            s_ready = (c == 1 + v.readyDelay) ? (4'b0001 << v.slave) : 4'b0000;
            if (c == 1 + v.readyDelay) s_rdata[v.slave*32 +: 32] = v.rdata;
            if (c == 2) begin
                checkOutput({v.name, " s_valid in WAIT"}, 32'(s_valid), 32'h0);
                if (v.strayReady != 4'b0000) begin
                    s_ready = s_ready | v.strayReady;
                    m_valid = 1'b1;
                    m_addr  = 32'h00020000;
                end
            end
            if (m_ready) begin
                respCycle = c;
                gotRdata  = m_rdata;
                gotErr    = m_error;
                gotSaddr  = s_addr;
                break;
            end
        end
        s_ready = 4'b0000;
        s_rdata = IdleRdata;
        m_valid = 1'b0;
        checkOutput({v.name, " response cycle"}, 32'(respCycle), 32'(v.expCycle));
        checkOutput({v.name, " m_rdata"}, gotRdata, v.rdata);
        checkOutput({v.name, " m_error"}, 32'(gotErr), 32'h0);
        checkOutput({v.name, " s_addr hold"}, gotSaddr, v.expSaddr);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors[0] = '{"dram read",      32'h00020010, 1'b0, 32'h0,        4'h0, 1, 32'hDEADBEEF, 2, 4'b0000, 4'b0010, 32'h10,    4};
        vectors[1] = '{"uart write",     32'h00100000, 1'b0, 32'h41,       4'h1, 2, 32'h12345678, 1, 4'b0000, 4'b0100, 32'h0,     3};
        vectors[2] = '{"iram fetch",     32'h00000000, 1'b1, 32'h0,        4'h0, 0, 32'h00000013, 1, 4'b0000, 4'b0001, 32'h0,     3};
        vectors[3] = '{"timer stray",    32'h0020000C, 1'b0, 32'h0,        4'h0, 3, 32'hCAFEF00D, 3, 4'b0001, 4'b1000, 32'hC,     5};
        vectors[4] = '{"dram last word", 32'h0003FFFC, 1'b0, 32'hA5A5A5A5, 4'hF, 1, 32'h55AA55AA, 4, 4'b0000, 4'b0010, 32'h1FFFC, 6};
        vectors[5] = '{"uart top-1",     32'h00100003, 1'b0, 32'hFF,       4'h2, 2, 32'h0BADF00D, 1, 4'b0000, 4'b0100, 32'h3,     3};
        vectors[6] = '{"recovery",       32'h00200008, 1'b1, 32'h77,       4'hC, 3, 32'h600DCAFE, 2, 4'b0000, 4'b1000, 32'h8,     4};

        reset   = 1'b1;
        m_valid = 1'b0;
        m_instr = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        s_ready = '0;
        s_rdata = IdleRdata;
        repeat (2) @(negedge clock);
        checkOutput("reset m_rdata", m_rdata, 32'h0);
        checkOutput("reset s_addr/wdata", s_addr | s_wdata, 32'h0);
        checkOutput("reset flags", 32'({m_ready, m_error, s_valid, s_instr, s_wstrb}), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) applyStimulus(vectors[i]);

        // Reset lands during WAIT of a dram request; no response may follow.
        @(negedge clock);
        m_valid = 1'b1;
        m_addr  = 32'h00020020;
        m_instr = 1'b1;
        m_wdata = 32'h89ABCDEF;
        m_wstrb = 4'h3;
        @(negedge clock);
        m_valid = 1'b0;
        checkOutput("midreset s_valid", 32'(s_valid), 32'h2);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("midreset m_rdata", m_rdata, 32'h0);
        checkOutput("midreset s_addr", s_addr, 32'h0);
        checkOutput("midreset s_wdata", s_wdata, 32'h0);
        checkOutput("midreset flags", 32'({m_ready, m_error, s_valid, s_instr, s_wstrb}), 32'h0);
        for (int c = 4; c <= 8; c++) begin
            @(negedge clock);
            s_ready = (c <= 5) ? 4'b0010 : 4'b0000;
            checkOutput($sformatf("midreset no m_ready c%0d", c), 32'(m_ready), 32'h0);
        end
        s_ready = 4'b0000;
        applyStimulus(vectors[6]);

        // Timeout of 4 on a silent timer: ERR at cycle 6, late ready at 8 ignored.
        @(negedge clock);
        m_valid = 1'b1;
        m_addr  = 32'h00200004;
        m_wstrb = 4'h0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            m_valid = 1'b0;
            s_ready = (c == 8) ? 4'b1000 : 4'b0000;
            if (c == 1) checkOutput("timeout s_valid", 32'(s_valid), 32'h8);
            if (c == 6) checkOutput("timeout m_rdata", m_rdata, 32'h0);
            checkOutput($sformatf("timeout ready/error c%0d", c), 32'({m_ready, m_error}),
                        (c == 6) ? 32'h3 : 32'h0);
        end
        s_ready = 4'b0000;

        applyStimulus(vectors[0]);

        // Unmapped: dram's exclusive top falls in no window.
        @(negedge clock);
        m_valid = 1'b1;
        m_addr  = 32'h00040000;
        @(negedge clock);
        m_valid = 1'b0;
        checkOutput("unmapped ready/error", 32'({m_ready, m_error}), 32'h3);
        checkOutput("unmapped m_rdata", m_rdata, 32'h0);
        checkOutput("unmapped s_valid", 32'(s_valid), 32'h0);
        @(negedge clock);
        checkOutput("unmapped after", 32'({m_ready, m_error, s_valid}), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
